timer_ctrl: RTL and testbench

Command-driven controller that sequences the shared timebase: a prescaler that generates a periodic tick, plus a period counter that signals expiry after a programmed number of ticks. It supports one-shot or periodic operation with start/stop/pause/resume commands and replaces free-running per-unit timers. Both counters are instances of the team's generic `register` (ctrl NONE/LOAD/INCR/CLR) and are sequenced entirely by this block's FSM.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_ctrl_if.sv | 25 ++
 rtl/register.sv | 28 ++
 rtl/timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_timer_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the timebase controller and its counters.
package timer_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  // Operation selector for the generic register
  typedef enum logic [1:0] {
    NONE = 2'd0,
    LOAD = 2'd1,
    INCR = 2'd2,
    CLR  = 2'd3
  } reg_ctrl_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Command and status bundle between a timer client (master) and timer_ctrl (slave).
interface timer_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [CNT_WIDTH-1:0] cmd_period;
  logic                 cmd_periodic;
  logic                 tick;
  logic                 expired;
  logic                 cmd_err;
  logic                 busy;
  logic [CNT_WIDTH-1:0] remaining;

  modport master (
    output cmd_valid, cmd_op, cmd_period, cmd_periodic,
    input  cmd_ready, tick, expired, cmd_err, busy, remaining
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_period, cmd_periodic,
    output cmd_ready, tick, expired, cmd_err, busy, remaining
  );
endinterface

// File: rtl/register.sv
// Generic counter/holding register: hold, load, increment or clear per cycle.
module register
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_nreset,
  input  reg_ctrl_t        ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Apply the selected operation on each rising edge; reset clears the value
  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      data_out <= '0;
    end else begin
      case (ctrl)
        LOAD:    data_out <= data_in;
        INCR:    data_out <= data_out + WIDTH'(1);
        CLR:     data_out <= '0;
        default: data_out <= data_out;
      endcase
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven timebase: prescaler tick generator plus period counter with
// one-shot/periodic expiry, sequenced by a small IDLE/RUN/PAUSED FSM.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       sync_nreset,
  timer_ctrl_if.slave bus
);

  localparam int             PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state_reg;
  logic                 periodic_reg;
  logic [CNT_WIDTH-1:0] period_reg;
  logic                 cmd_err_reg;

  logic [PW-1:0]        prescaler;
  logic [CNT_WIDTH-1:0] remaining;

  reg_ctrl_t            pre_ctrl;
  reg_ctrl_t            rem_ctrl;
  logic [CNT_WIDTH-1:0] rem_din;

  logic at_last;
  logic tick_now;
  logic expire_now;
  logic cmd_start;
  logic cmd_stop;
  logic cmd_pause;
  logic cmd_resume;
  logic cmd_bad;

  assign at_last    = (prescaler == PS_LAST);
  assign tick_now   = (state_reg == S_RUN) && at_last;
  assign expire_now = tick_now && (remaining == ONE);

  // Classify the incoming command as one legal action or an illegal one
  always_comb begin
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    cmd_pause  = 1'b0;
    cmd_resume = 1'b0;
    cmd_bad    = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.cmd_op)
        OP_START: begin
          if (bus.cmd_period != '0) cmd_start = 1'b1;
          else                      cmd_bad   = 1'b1;
        end
        OP_STOP: cmd_stop = 1'b1;
        OP_PAUSE: begin
          if (state_reg == S_RUN) cmd_pause = 1'b1;
          else                    cmd_bad   = 1'b1;
        end
        OP_RESUME: begin
          if (state_reg == S_PAUSED) cmd_resume = 1'b1;
          else                       cmd_bad    = 1'b1;
        end
        default: cmd_bad = 1'b1;
      endcase
    end
  end

  // Drive both counters: normal RUN counting first, then let a legal command override it.
  // PAUSE freezes only the remaining count; the prescaler still takes its RUN step that
  // cycle, so the value held while paused is the one it would have reached.
  always_comb begin
    pre_ctrl = NONE;
    rem_ctrl = NONE;
    rem_din  = remaining - ONE;
    if (state_reg == S_RUN) begin
      pre_ctrl = at_last ? CLR : INCR;
    end
    if (tick_now) begin
      if (remaining > ONE) begin
        rem_ctrl = LOAD;
      end else if (periodic_reg) begin
        rem_ctrl = LOAD;
        rem_din  = period_reg;
      end else begin
        rem_ctrl = CLR;
      end
    end
    if (cmd_start) begin
      pre_ctrl = CLR;
      rem_ctrl = LOAD;
      rem_din  = bus.cmd_period;
    end else if (cmd_stop) begin
      pre_ctrl = CLR;
      rem_ctrl = CLR;
    end else if (cmd_pause) begin
      rem_ctrl = NONE;
    end
  end

  // Controller FSM with the registered error pulse, period and reload-mode latches
  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      state_reg    <= S_IDLE;
      periodic_reg <= 1'b0;
      period_reg   <= '0;
      cmd_err_reg  <= 1'b0;
    end else begin
      cmd_err_reg <= cmd_bad;
      if (cmd_start) begin
        state_reg    <= S_RUN;
        period_reg   <= bus.cmd_period;
        periodic_reg <= bus.cmd_periodic;
      end else if (cmd_stop) begin
        state_reg <= S_IDLE;
      end else if (cmd_pause) begin
        state_reg <= S_PAUSED;
      end else if (cmd_resume) begin
        state_reg <= S_RUN;
      end else if (expire_now && !periodic_reg) begin
        state_reg <= S_IDLE;
      end
    end
  end

  register #(.WIDTH(PW)) u_prescaler (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .ctrl       (pre_ctrl),
    .data_in    ({PW{1'b0}}),
    .data_out   (prescaler)
  );

  register #(.WIDTH(CNT_WIDTH)) u_remaining (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .ctrl       (rem_ctrl),
    .data_in    (rem_din),
    .data_out   (remaining)
  );

  assign bus.cmd_ready = 1'b1;
  assign bus.tick      = tick_now;
  assign bus.expired   = expire_now;
  assign bus.cmd_err   = cmd_err_reg;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.remaining = remaining;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with PRESCALE=4, CNT_WIDTH=8.
// "Cycle t+k" is the k-th clock period after the edge t that accepted the command.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic clk;
  logic sync_nreset;
  int   total;
  int   bad;
  int   cyc;

  timer_ctrl_if #(.CNT_WIDTH(8)) bus ();

  timer_ctrl #(.PRESCALE(4), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present one command for the current cycle
  task automatic issue(input logic [1:0] op, input logic [7:0] per, input logic pd);
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_period   = per;
    bus.cmd_periodic = pd;
    $display("cmd cycle=%0d op=%0d period=%0d periodic=%0d", cyc, op, per, pd);
  endtask

  // Advance past the next rising edge and withdraw any command
  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    sync_nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sync_nreset = 1'b1;
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== 12'h000) begin
      bad++; $display("FAIL reset_state got=%h exp=000", got);
    end
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready);
    end
    next_cycle();
    // Start a run, then pulse reset low between edges: must be ignored
    issue(OP_START, 8'd3, 1'b0);
    next_cycle();
    #1 sync_nreset = 1'b0;
    #2 sync_nreset = 1'b1;
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd3}) begin
      bad++; $display("FAIL reset_glitch got=%h exp=%h", got, {1'b0, 1'b0, 1'b0, 1'b1, 8'd3});
    end
    next_cycle();
    // Reset held across an edge mid-RUN aborts silently
    sync_nreset = 1'b0;
    next_cycle();
    sync_nreset = 1'b1;
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== 12'h000) begin
      bad++; $display("FAIL reset_midrun got=%h exp=000", got);
    end
    next_cycle();
  endtask

  task automatic test_oneshot();
    logic [11:0] got, exp;
    logic t, x, b;
    logic [7:0] r;
    issue(OP_START, 8'd3, 1'b0);
    next_cycle();
    for (int k = 1; k <= 14; k++) begin
      t = (k % 4 == 0) && (k <= 12);
      x = (k == 12);
      b = (k <= 12);
      r = b ? 8'(3 - (k - 1) / 4) : 8'd0;
      exp = {t, x, 1'b0, b, r};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL oneshot k=%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_periodic();
    logic [11:0] got, exp;
    logic t, x;
    logic [7:0] r;
    issue(OP_START, 8'd2, 1'b1);
    next_cycle();
    for (int k = 1; k <= 20; k++) begin
      t = (k % 4 == 0);
      x = (k % 8 == 0);
      r = 8'(2 - ((k - 1) / 4) % 2);
      exp = {t, x, 1'b0, 1'b1, r};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL periodic k=%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
    issue(OP_STOP, 8'd0, 1'b0);
    next_cycle();
  endtask

  task automatic test_pause_resume();
    logic [11:0] got, exp;
    logic t, x, b;
    logic [7:0] r;
    int e;
    bit running;
    issue(OP_START, 8'd5, 1'b0);
    next_cycle();
    for (int k = 1; k <= 32; k++) begin
      if (k == 6)  issue(OP_PAUSE, 8'd0, 1'b0);
      if (k == 16) issue(OP_RESUME, 8'd0, 1'b0);
      // e = elapsed counting cycles; frozen for the 10 paused cycles
      if (k <= 6)       e = k;
      else if (k <= 16) e = 6;
      else              e = k - 10;
      running = (k <= 6) || (k >= 17 && e <= 20);
      t = running && (e % 4 == 0);
      x = t && (e == 20);
      b = (k <= 16) || (e <= 20);
      r = b ? 8'(5 - (e - 1) / 4) : 8'd0;
      exp = {t, x, 1'b0, b, r};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic [11:0] got, exp;
    logic t, err;
    logic [7:0] r;
    issue(OP_PAUSE, 8'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== 12'h200) begin
      bad++; $display("FAIL pause_idle got=%h exp=200", got);
    end
    issue(OP_STOP, 8'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== 12'h000) begin
      bad++; $display("FAIL stop_idle got=%h exp=000", got);
    end
    issue(OP_RESUME, 8'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
    total++;
    if (got !== 12'h200) begin
      bad++; $display("FAIL resume_idle got=%h exp=200", got);
    end
    next_cycle();
    issue(OP_START, 8'd6, 1'b0);
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) issue(OP_RESUME, 8'd0, 1'b0);
      if (k == 5) issue(OP_START, 8'd0, 1'b1);
      t   = (k % 4 == 0);
      err = (k == 3) || (k == 6);
      r   = 8'(6 - (k - 1) / 4);
      exp = {t, 1'b0, err, 1'b1, r};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL illegal_run k=%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
    issue(OP_STOP, 8'd0, 1'b0);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    logic t, x, b;
    logic [7:0] r;
    int kk;
    issue(OP_START, 8'd1, 1'b0);
    next_cycle();
    for (int k = 1; k <= 22; k++) begin
      if (k == 4) issue(OP_START, 8'd4, 1'b0);
      if (k <= 4) begin
        t = (k == 4); x = (k == 4); b = 1'b1; r = 8'd1;
      end else begin
        kk = k - 4;
        b = (kk <= 16);
        t = b && (kk % 4 == 0);
        x = (kk == 16);
        r = b ? 8'(4 - (kk - 1) / 4) : 8'd0;
      end
      exp = {t, x, 1'b0, b, r};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp);
      end
      next_cycle();
    end
  endtask

  // Random commands against a spec-level model (mode 0 idle, 1 run, 2 paused)
  task automatic test_random();
    logic [11:0] got, exp;
    int mode, phase, left, reload, n_mode, n_phase, n_left;
    bit rep, err_p, n_err, cv, et, ex;
    logic [1:0] op;
    logic [7:0] per;
    logic pd;
    mode = 0; phase = 0; left = 0; reload = 0; rep = 0; err_p = 0;
    for (int i = 0; i < 400; i++) begin
      cv = ($urandom_range(0, 5) == 0);
      op = 2'($urandom_range(0, 3));
      per = 8'($urandom_range(0, 3));
      pd = 1'($urandom_range(0, 1));
      if (cv) issue(op, per, pd);
      et = (mode == 1) && (phase == 3);
      ex = et && (left == 1);
      exp = {et, ex, err_p, (mode != 0), 8'(left)};
      @(negedge clk);
      got = {bus.tick, bus.expired, bus.cmd_err, bus.busy, bus.remaining};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp);
      end
      n_mode = mode; n_phase = phase; n_left = left; n_err = 0;
      if (mode == 1) begin
        n_phase = (phase + 1) % 4;
        if (et) begin
          if (left > 1)  n_left = left - 1;
          else if (rep)  n_left = reload;
          else begin n_left = 0; n_mode = 0; end
        end
      end
      if (cv) begin
        case (op)
          OP_START: begin
            if (per == 0) n_err = 1;
            else begin
              n_phase = 0; n_left = int'(per); reload = int'(per); rep = pd; n_mode = 1;
            end
          end
          OP_STOP: begin n_phase = 0; n_left = 0; n_mode = 0; end
          OP_PAUSE: begin
            if (mode == 1) begin n_left = left; n_mode = 2; end
            else n_err = 1;
          end
          default: begin
            if (mode == 2) n_mode = 1;
            else n_err = 1;
          end
        endcase
      end
      mode = n_mode; phase = n_phase; left = n_left; err_p = n_err;
      next_cycle();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    sync_nreset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_STOP;
    bus.cmd_period = 8'd0;
    bus.cmd_periodic = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_resume();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
